// File: rtl/pic_irq_core_n.sv
// Interrupt-priority core: IRR/ISR/IMR, fixed or rotating priority, edge/level
// trigger, normal/auto EOI, and vector = base + index on a single-cycle acknowledge.
module pic_irq_core_n #(
    parameter int unsigned N_IRQ = 8,
    parameter int unsigned VEC_W = 8,
    parameter int unsigned IDX_W = $clog2(N_IRQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             level_mode,
    input  logic             rotate_mode,
    input  logic             auto_eoi,
    input  logic [VEC_W-1:0] vector_base,
    input  logic             imr_we,
    input  logic [N_IRQ-1:0] imr_wdata,
    input  logic             inta,
    input  logic             eoi,
    input  logic             eoi_specific,
    input  logic [IDX_W-1:0] eoi_level,
    output logic             int_out,
    output logic             vec_valid,
    output logic [VEC_W-1:0] vec_out,
    output logic [N_IRQ-1:0] irr,
    output logic [N_IRQ-1:0] isr,
    output logic [N_IRQ-1:0] imr
);

    localparam logic [IDX_W-1:0] LP_RST = IDX_W'(N_IRQ - 1);

    logic [N_IRQ-1:0] irq_q;
    logic [IDX_W-1:0] lp;

    logic [N_IRQ-1:0] pend;
    logic             win_found;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] win_rank;
    logic             srv_found;
    logic [IDX_W-1:0] srv_idx;
    logic [IDX_W-1:0] srv_rank;

    logic             ack_hit;
    logic [N_IRQ-1:0] ack_oh;
    logic [N_IRQ-1:0] ack_set;
    logic [N_IRQ-1:0] eoi_clr;
    logic             eoi_hit;
    logic [IDX_W-1:0] eoi_idx;
    logic [N_IRQ-1:0] irr_nxt;
    logic [N_IRQ-1:0] isr_nxt;
    logic [IDX_W-1:0] lp_nxt;
    logic [VEC_W-1:0] vec_nxt;

    // Index at priority rank 'off' (0 = highest), given lowest-priority index 'base'.
    function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base,
                                                 input int unsigned off);
        int unsigned s;
        s = 32'(base) + 32'd1 + off;
        if (s >= N_IRQ) s = s - N_IRQ;
        return IDX_W'(s);
    endfunction

    // Priority scan of pending requests and of in-service bits.
    always_comb begin
        pend      = irr & ~imr;
        win_found = 1'b0;
        win_idx   = '0;
        win_rank  = '0;
        srv_found = 1'b0;
        srv_idx   = '0;
        srv_rank  = '0;
        for (int unsigned k = 0; k < N_IRQ; k++) begin
            if (!win_found && pend[rot_idx(lp, k)]) begin
                win_found = 1'b1;
                win_idx   = rot_idx(lp, k);
                win_rank  = IDX_W'(k);
            end
            if (!srv_found && isr[rot_idx(lp, k)]) begin
                srv_found = 1'b1;
                srv_idx   = rot_idx(lp, k);
                srv_rank  = IDX_W'(k);
            end
        end
    end

    assign int_out = win_found && (!srv_found || (win_rank < srv_rank));

    // Acknowledge is taken from pre-EOI state; EOI clears, then acknowledge sets.
    always_comb begin
        ack_hit = inta && win_found;
        ack_oh  = ack_hit ? (N_IRQ'(1) << win_idx) : '0;
        ack_set = auto_eoi ? '0 : ack_oh;
        eoi_idx = eoi_specific ? eoi_level : srv_idx;
        eoi_clr = '0;
        if (eoi) begin
            if (eoi_specific)   eoi_clr = N_IRQ'(1) << eoi_level;
            else if (srv_found) eoi_clr = N_IRQ'(1) << srv_idx;
        end
        eoi_hit = |(isr & eoi_clr);

        if (level_mode) irr_nxt = irq_in & ~ack_oh;
        else            irr_nxt = (irr & ~ack_oh) | (irq_in & ~irq_q);
        isr_nxt = (isr & ~eoi_clr) | ack_set;

        lp_nxt = lp;
        if (!rotate_mode)             lp_nxt = LP_RST;
        else if (ack_hit && auto_eoi) lp_nxt = win_idx;
        else if (eoi_hit)             lp_nxt = eoi_idx;

        if (ack_hit) vec_nxt = vector_base + VEC_W'(win_idx);
        else         vec_nxt = vector_base + VEC_W'(N_IRQ - 1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_q     <= '0;
            irr       <= '0;
            isr       <= '0;
            imr       <= '0;
            lp        <= LP_RST;
            vec_valid <= 1'b0;
            vec_out   <= '0;
        end else begin
            irq_q     <= irq_in;
            irr       <= irr_nxt;
            isr       <= isr_nxt;
            lp        <= lp_nxt;
            vec_valid <= inta;
            if (imr_we) imr <= imr_wdata;
            if (inta)   vec_out <= vec_nxt;
        end
    end

endmodule
